// File: rtl/rand_block_collector_pkg.sv
// Shared defaults and FSM state encoding for the random-block collector and
// the producer benches that drive it.
package rand_block_collector_pkg;

  localparam int REGISTER_SIZE_DEF = 32;
  localparam int TOTAL_BITS_DEF    = 4096;
  localparam int GAP_LIMIT_DEF     = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRIGGER = 2'd1,
    COLLECT = 2'd2,
    HOLD    = 2'd3
  } state_t;

endpackage

// File: rtl/rand_block_collector_gap_timer.sv
// Counts consecutive idle cycles; o_expired flags the tick on which the count
// reaches LIMIT. LIMIT = 0 never expires. The count saturates instead of wrapping.
module rand_block_collector_gap_timer #(
  parameter int LIMIT = 8,
  parameter int W     = $clog2(LIMIT + 1) + 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_expired
);

  localparam logic [W-1:0] LAST = (LIMIT > 0) ? W'(LIMIT - 1) : '0;
  localparam logic [W-1:0] SAT  = '1;

  logic [W-1:0] r_cnt;

  // idle-cycle counter: clear wins over tick
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_tick && (r_cnt != SAT)) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expired = (LIMIT > 0) && i_tick && !i_clear && (r_cnt == LAST);

endmodule

// File: rtl/rand_block_collector.sv
// Triggers a block producer, assembles NUM_BLOCKS consecutive blocks (LSB first)
// into one wide word and offers it downstream with a valid/ready handshake.
module rand_block_collector
  import rand_block_collector_pkg::*;
#(
  parameter int REGISTER_SIZE = REGISTER_SIZE_DEF,
  parameter int TOTAL_BITS    = TOTAL_BITS_DEF,
  parameter int GAP_LIMIT     = GAP_LIMIT_DEF
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start_in,
  output logic                     trigger_out,
  input  logic [REGISTER_SIZE-1:0] block_in,
  input  logic                     block_valid_in,
  output logic [TOTAL_BITS-1:0]    data_out,
  output logic                     data_valid_out,
  input  logic                     data_ready_in,
  output logic                     busy_out,
  output logic                     error_out
);

  localparam int NUM_BLOCKS = TOTAL_BITS / REGISTER_SIZE;
  localparam int CNT_W      = $clog2(NUM_BLOCKS) + 1;
  localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(NUM_BLOCKS - 1);

  state_t                r_state;
  logic [CNT_W-1:0]      r_blk_cnt;
  logic                  w_capture;
  logic                  w_gap_clear;
  logic                  w_gap_tick;
  logic                  w_gap_expired;
  logic [NUM_BLOCKS-1:0] w_blk_we;

  assign w_capture   = (r_state == COLLECT) && block_valid_in;
  assign w_gap_clear = (r_state == TRIGGER) || w_capture;
  assign w_gap_tick  = (r_state == COLLECT) && !block_valid_in;

  rand_block_collector_gap_timer #(
    .LIMIT (GAP_LIMIT)
  ) u_gap_timer (
    .i_clk     (clk_in),
    .i_rst     (rst_in),
    .i_clear   (w_gap_clear),
    .i_tick    (w_gap_tick),
    .o_expired (w_gap_expired)
  );

  // one-hot write enable for the slot addressed by the block count
  always_comb begin
    w_blk_we = '0;
    for (int k = 0; k < NUM_BLOCKS; k++) begin
      w_blk_we[k] = w_capture && (r_blk_cnt == CNT_W'(k));
    end
  end

  // wide word storage; untouched outside COLLECT so a timed-out partial word stays visible
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      data_out <= '0;
    end else begin
      for (int k = 0; k < NUM_BLOCKS; k++) begin
        if (w_blk_we[k]) begin
          data_out[k*REGISTER_SIZE +: REGISTER_SIZE] <= block_in;
        end
      end
    end
  end

  // control FSM with registered outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state        <= IDLE;
      r_blk_cnt      <= '0;
      trigger_out    <= 1'b0;
      data_valid_out <= 1'b0;
      busy_out       <= 1'b0;
      error_out      <= 1'b0;
    end else begin
      trigger_out <= 1'b0;
      error_out   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_in) begin
            r_state     <= TRIGGER;
            trigger_out <= 1'b1;
            busy_out    <= 1'b1;
          end
        end
        TRIGGER: begin
          r_blk_cnt <= '0;
          r_state   <= COLLECT;
        end
        COLLECT: begin
          if (w_capture) begin
            r_blk_cnt <= r_blk_cnt + 1'b1;
            if (r_blk_cnt == LAST_BLK) begin
              r_state        <= HOLD;
              data_valid_out <= 1'b1;
            end
          end else if (w_gap_expired) begin
            r_state   <= IDLE;
            error_out <= 1'b1;
            busy_out  <= 1'b0;
          end
        end
        HOLD: begin
          if (data_ready_in) begin
            r_state        <= IDLE;
            data_valid_out <= 1'b0;
            busy_out       <= 1'b0;
          end
        end
        default: begin
          r_state        <= IDLE;
          data_valid_out <= 1'b0;
          busy_out       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rand_block_collector.sv
// Directed bench for rand_block_collector with default parameters (32 x 128 blocks).
module tb_rand_block_collector;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          trig;
  logic [31:0]   blk;
  logic          bvalid;
  logic [4095:0] dout;
  logic          dvalid;
  logic          ready;
  logic          busy;
  logic          err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int trig_cnt, err_cnt, busy_hi, valid_cyc, err_cyc;

  rand_block_collector dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .start_in       (start),
    .trigger_out    (trig),
    .block_in       (blk),
    .block_valid_in (bvalid),
    .data_out       (dout),
    .data_valid_out (dvalid),
    .data_ready_in  (ready),
    .busy_out       (busy),
    .error_out      (err)
  );

  always #5 clk = ~clk;

  task automatic clear_obs();
    trig_cnt  = 0;
    err_cnt   = 0;
    busy_hi   = 0;
    valid_cyc = -1;
    err_cyc   = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (trig) trig_cnt++;
    if (busy) busy_hi++;
    if (err) err_cnt++;
    if (err && err_cyc < 0) err_cyc = cyc;
    if (dvalid && valid_cyc < 0) valid_cyc = cyc;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic [4095:0] exp);
    int idx;
    idx = 0;
    for (int k = 127; k >= 0; k--) begin
      if (dout[k*32 +: 32] !== exp[k*32 +: 32]) idx = k;
    end
    total++;
    assert (dout === exp) else begin
      bad++;
      $error("FAIL %s first_bad_blk=%0d got=%h exp=%h", tag, idx, dout[idx*32 +: 32], exp[idx*32 +: 32]);
    end
  endtask

  function automatic logic [31:0] blk_val(input int mode, input int k);
    case (mode)
      0:       blk_val = (k == 0) ? 32'd1 : 32'd0;
      1:       blk_val = 32'(k + 1);
      2:       blk_val = {16'hC0DE, 16'(k)};
      default: blk_val = ~32'(k);
    endcase
  endfunction

  function automatic logic [4095:0] exp_word(input int mode);
    logic [4095:0] w;
    w = '0;
    for (int k = 0; k < 128; k++) w[k*32 +: 32] = blk_val(mode, k);
    return w;
  endfunction

  // start pulse; returns the cycle in which trigger_out is high
  task automatic start_pulse(output int t);
    start = 1'b1;
    tick();
    t = cyc;
    chk("trigger_hi", 64'(trig), 64'd1);
    chk("busy_at_trigger", 64'(busy), 64'd1);
    start = 1'b0;
    tick();
    chk("trigger_one_cycle", 64'(trig), 64'd0);
  endtask

  // contiguous producer starting at T+1, optional stall before block stall_at
  task automatic produce(input int mode, input int nblk, input int stall_at,
                         input int stall_len, input int tail);
    for (int k = 0; k < nblk; k++) begin
      if (k == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          bvalid = 1'b0;
          tick();
        end
      end
      blk    = blk_val(mode, k);
      bvalid = 1'b1;
      tick();
    end
    bvalid = 1'b0;
    blk    = '0;
    for (int s = 0; s < tail; s++) tick();
  endtask

  initial begin
    int t;
    int unstable;
    logic [4095:0] snap;

    rst = 1'b1; start = 1'b0; bvalid = 1'b0; blk = '0; ready = 1'b1;
    clear_obs();
    tick();
    tick();
    chk("rst_trigger", 64'(trig), 64'd0);
    chk("rst_valid", 64'(dvalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_error", 64'(err), 64'd0);
    chk_data("rst_data", '0);
    rst = 1'b0;
    clear_obs();
    tick(); tick(); tick();
    chk("release_no_trigger", 64'(trig_cnt), 64'd0);
    chk("release_idle", 64'(busy), 64'd0);

    // 1: single-one word, ready held high
    clear_obs();
    start_pulse(t);
    produce(0, 128, -1, 0, 0);
    chk("t1_latency", 64'(valid_cyc - t), 64'd129);
    chk("t1_valid", 64'(dvalid), 64'd1);
    chk_data("t1_data", 4096'd1);
    chk("t1_trig_count", 64'(trig_cnt), 64'd1);
    tick();
    chk("t1_idle_valid", 64'(dvalid), 64'd0);
    chk("t1_idle_busy", 64'(busy), 64'd0);

    // 2: counting blocks, ready held low for 20 cycles with junk blocks arriving
    ready = 1'b0;
    clear_obs();
    start_pulse(t);
    produce(1, 128, -1, 0, 0);
    chk("t2_latency", 64'(valid_cyc - t), 64'd129);
    chk("t2_low_word", 64'(dout[31:0]), 64'd1);
    chk("t2_high_word", 64'(dout[4095:4064]), 64'd128);
    chk_data("t2_data", exp_word(1));
    snap = dout;
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      blk    = $urandom;
      bvalid = i[0];
      tick();
      if (dout !== snap || dvalid !== 1'b1) unstable++;
    end
    chk("t2_hold_stable", 64'(unstable), 64'd0);
    ready  = 1'b1;
    bvalid = 1'b0;
    tick();
    chk("t2_after_hs_valid", 64'(dvalid), 64'd0);
    chk("t2_after_hs_busy", 64'(busy), 64'd0);
    chk_data("t2_extra_dropped", exp_word(1));
    chk("t2_trig_count", 64'(trig_cnt), 64'd1);

    // 3: 5-cycle stall after block 63 stays under the gap limit
    clear_obs();
    start_pulse(t);
    produce(2, 128, 64, 5, 0);
    chk("t3_latency", 64'(valid_cyc - t), 64'd134);
    chk("t3_no_error", 64'(err_cnt), 64'd0);
    chk_data("t3_data", exp_word(2));
    tick();
    chk("t3_idle_valid", 64'(dvalid), 64'd0);

    // 4: producer stops after block 10 -> timeout 8 cycles after the last capture edge
    clear_obs();
    start_pulse(t);
    produce(3, 11, -1, 0, 12);
    chk("t4_error_cycle", 64'(err_cyc - t), 64'd20);
    chk("t4_error_once", 64'(err_cnt), 64'd1);
    chk("t4_never_valid", 64'(valid_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t4_idle", 64'(busy), 64'd0);
    chk("t4_partial_blk10", 64'(dout[10*32 +: 32]), 64'(blk_val(3, 10)));
    chk("t4_retained_blk11", 64'(dout[11*32 +: 32]), 64'(blk_val(2, 11)));
    clear_obs();
    start_pulse(t);
    produce(3, 128, -1, 0, 0);
    chk("t4_clean_latency", 64'(valid_cyc - t), 64'd129);
    chk("t4_clean_no_error", 64'(err_cnt), 64'd0);
    chk_data("t4_clean_data", exp_word(3));
    tick();

    // 5: stale stream in IDLE, start held through COLLECT/HOLD, retrigger after handshake
    clear_obs();
    for (int i = 0; i < 10; i++) begin
      blk    = 32'hFFFF_FFFF;
      bvalid = i[0];
      tick();
    end
    bvalid = 1'b0;
    chk("t5_idle_no_trigger", 64'(trig_cnt), 64'd0);
    chk("t5_idle_not_busy", 64'(busy_hi), 64'd0);
    chk_data("t5_idle_no_capture", exp_word(3));
    ready = 1'b0;
    clear_obs();
    start_pulse(t);
    start = 1'b1;
    produce(0, 128, -1, 0, 0);
    chk("t5_busy_span", 64'(busy_hi), 64'd130);
    tick(); tick(); tick();
    chk("t5_no_extra_trigger", 64'(trig_cnt), 64'd1);
    ready = 1'b1;
    tick();
    chk("t5_hs_no_trigger", 64'(trig), 64'd0);
    chk("t5_hs_idle", 64'(busy), 64'd0);
    tick();
    chk("t5_retrigger", 64'(trig), 64'd1);
    start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("t5_retrigger_timeout", 64'(err_cnt), 64'd1);
    chk("t5_final_idle", 64'(busy), 64'd0);

    // 6: asynchronous reset in the middle of COLLECT
    clear_obs();
    start_pulse(t);
    produce(1, 40, -1, 0, 0);
    chk("t6_busy_mid", 64'(busy), 64'd1);
    bvalid = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk("t6_async_busy", 64'(busy), 64'd0);
    chk("t6_async_trig", 64'(trig), 64'd0);
    chk("t6_async_valid", 64'(dvalid), 64'd0);
    chk_data("t6_async_data", '0);
    tick();
    #3;
    rst = 1'b0;
    clear_obs();
    for (int i = 0; i < 10; i++) begin
      bvalid = i[0];
      blk    = 32'h1234_5678;
      tick();
    end
    bvalid = 1'b0;
    chk("t6_no_trigger_after", 64'(trig_cnt), 64'd0);
    chk("t6_idle_after", 64'(busy_hi), 64'd0);
    chk_data("t6_no_capture_after", '0);
    clear_obs();
    start_pulse(t);
    produce(2, 128, -1, 0, 0);
    chk("t6_restart_latency", 64'(valid_cyc - t), 64'd129);
    chk_data("t6_restart_data", exp_word(2));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
